// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// Holds the FSM state enum, requester index type and fixed AXI field values.
package axi_read_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAr   = 2'd1,
      StR    = 2'd2
   } state_e;

   typedef enum logic {
      ReqInst = 1'b0,
      ReqData = 1'b1
   } req_idx_e;

   localparam logic [3:0] INST_ID    = 4'd0;
   localparam logic [3:0] DATA_ID    = 4'd1;
   localparam logic [1:0] BURST_INCR = 2'b01;

   function automatic logic [3:0] req_id(req_idx_e r);
      return (r == ReqData) ? DATA_ID : INST_ID;
   endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last. Bit 0 is inst, bit 1 is data.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates inst and data read bursts onto one AXI master port, one burst in
// flight; R beats are steered back to the owner and trusted to end on rlast.
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
(
   input  logic        clock,
   input  logic        reset,

   input  logic        inst_req_valid,
   output logic        inst_req_ready,
   input  logic [31:0] inst_req_addr,
   input  logic [7:0]  inst_req_len,
   input  logic [2:0]  inst_req_size,
   output logic        inst_resp_valid,
   output logic [31:0] inst_resp_data,
   output logic        inst_resp_last,
   output logic        inst_resp_err,

   input  logic        data_req_valid,
   output logic        data_req_ready,
   input  logic [31:0] data_req_addr,
   input  logic [7:0]  data_req_len,
   input  logic [2:0]  data_req_size,
   output logic        data_resp_valid,
   output logic [31:0] data_resp_data,
   output logic        data_resp_last,
   output logic        data_resp_err,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,

   output logic        id_mismatch
);

   state_e      state_q, state_d;
   req_idx_e    last_grant_q, last_grant_d;
   req_idx_e    sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic        mism_q, mism_d;
   logic [1:0]  gnt;
   logic        beat_ok;

   rr_arbiter2 u_rr (
      .req_i        ({data_req_valid, inst_req_valid}),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt)
   );

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      sel_d          = sel_q;
      addr_d         = addr_q;
      len_d          = len_q;
      size_d         = size_q;
      mism_d         = mism_q;
      inst_req_ready = 1'b0;
      data_req_ready = 1'b0;
      arvalid        = 1'b0;
      rready         = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Hold off the handshake during reset so no request is silently lost.
            if (gnt != 2'b00 && !reset) begin
               inst_req_ready = gnt[0];
               data_req_ready = gnt[1];
               sel_d          = gnt[1] ? ReqData : ReqInst;
               last_grant_d   = sel_d;
               addr_d         = gnt[1] ? data_req_addr : inst_req_addr;
               len_d          = gnt[1] ? data_req_len  : inst_req_len;
               size_d         = gnt[1] ? data_req_size : inst_req_size;
               state_d        = StAr;
            end
         end
         StAr: begin
            arvalid = 1'b1;
            if (arready) state_d = StR;
         end
         StR: begin
            rready = 1'b1;
            if (rvalid) begin
               if (rid != req_id(sel_q)) mism_d = 1'b1;
               if (rlast) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      beat_ok         = (state_q == StR) && rvalid && (rid == req_id(sel_q));
      inst_resp_valid = beat_ok && (sel_q == ReqInst);
      data_resp_valid = beat_ok && (sel_q == ReqData);
      inst_resp_data  = rdata;
      data_resp_data  = rdata;
      inst_resp_last  = rlast;
      data_resp_last  = rlast;
      inst_resp_err   = (rresp != 2'b00);
      data_resp_err   = (rresp != 2'b00);
   end

   assign arid        = req_id(sel_q);
   assign araddr      = addr_q;
   assign arlen       = len_q;
   assign arsize      = size_q;
   assign arburst     = BURST_INCR;
   assign arlock      = 2'b00;
   assign arcache     = 4'b0000;
   assign arprot      = 3'b000;
   assign id_mismatch = mism_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= ReqInst;
         sel_q        <= ReqInst;
         addr_q       <= '0;
         len_q        <= '0;
         size_q       <= '0;
         mism_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         size_q       <= size_d;
         mism_q       <= mism_d;
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench: table of directed bursts, a reset-mid-burst sequence and
// randomized traffic checked against a transaction-level arbitration model.
module tb_axi_read_arbiter;

   logic        clock, reset;
   logic        inst_req_valid, inst_req_ready, data_req_valid, data_req_ready;
   logic [31:0] inst_req_addr, data_req_addr;
   logic [7:0]  inst_req_len, data_req_len;
   logic [2:0]  inst_req_size, data_req_size;
   logic        inst_resp_valid, inst_resp_last, inst_resp_err;
   logic        data_resp_valid, data_resp_last, data_resp_err;
   logic [31:0] inst_resp_data, data_resp_data;
   logic [3:0]  arid, arcache, rid;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock, rresp;
   logic        arvalid, arready, rlast, rvalid, rready, id_mismatch;

   axi_read_arbiter dut (
      .clock(clock), .reset(reset),
      .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
      .inst_req_addr(inst_req_addr), .inst_req_len(inst_req_len),
      .inst_req_size(inst_req_size), .inst_resp_valid(inst_resp_valid),
      .inst_resp_data(inst_resp_data), .inst_resp_last(inst_resp_last),
      .inst_resp_err(inst_resp_err),
      .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
      .data_req_addr(data_req_addr), .data_req_len(data_req_len),
      .data_req_size(data_req_size), .data_resp_valid(data_resp_valid),
      .data_resp_data(data_resp_data), .data_resp_last(data_resp_last),
      .data_resp_err(data_resp_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .id_mismatch(id_mismatch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          v;
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  s;
   } rq_t;

   typedef struct {
      bit          rst;
      bit          iv;
      bit          dv;
      logic [31:0] ia;
      logic [31:0] da;
      logic [7:0]  len;
      logic [2:0]  size;
      int          ar_wait;
      int          err_beat;
      int          bad_beat;
      int          exp_g;
   } vec_t;

   int  n_chk  = 0;
   int  n_pass = 0;
   rq_t rq[2];
   bit  last_g;
   bit  mism_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive();
      inst_req_valid = rq[0].v; inst_req_addr = rq[0].a;
      inst_req_len   = rq[0].l; inst_req_size = rq[0].s;
      data_req_valid = rq[1].v; data_req_addr = rq[1].a;
      data_req_len   = rq[1].l; data_req_size = rq[1].s;
   endtask

   task automatic do_reset(input bit junk_r);
      rq[0].v = 1'b0; rq[1].v = 1'b0; drive();
      reset = 1'b1; arready = 1'b0; rvalid = junk_r; rid = 4'd0; rlast = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0; last_g = 1'b0; mism_exp = 1'b0;
      @(negedge clock);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_req_ready", {inst_req_ready, data_req_ready}, 0);
      chk("rst_resp_valid", {inst_resp_valid, data_resp_valid}, 0);
      chk("rst_id_mismatch", id_mismatch, 0);
      @(posedge clock); #1;
      rvalid = 1'b0;
   endtask

   // exp_g < 0 asks the model for the winner; bad_beat == -2 means random bad rids.
   task automatic run_burst(input int exp_g, input int ar_wait, input int err_beat,
                            input int bad_beat, input int gap_pct, input int abort_after,
                            input bit rand_resp);
      bit g, go, bad, fwd;
      logic [3:0]  eid;
      logic [31:0] la;
      logic [7:0]  ll;
      logic [2:0]  ls;
      int beat, cyc;
      if (exp_g >= 0) g = exp_g[0];
      else if (rq[0].v && rq[1].v) g = ~last_g;
      else g = rq[1].v;
      eid = g ? 4'd1 : 4'd0;
      la = rq[g].a; ll = rq[g].l; ls = rq[g].s;
      drive();
      rvalid = 1'b1; rid = eid; rlast = 1'b1; arready = 1'b0;
      @(negedge clock);
      chk("grant_inst_ready", inst_req_ready, !g);
      chk("grant_data_ready", data_req_ready, g);
      chk("idle_arvalid", arvalid, 0);
      chk("idle_rready", rready, 0);
      chk("idle_resp_valid", {inst_resp_valid, data_resp_valid}, 0);
      chk("id_mismatch", id_mismatch, mism_exp);
      @(posedge clock); #1;
      last_g = g;
      rq[g].v = 1'b0; rq[g].a = $urandom; rq[g].l = 8'($urandom); drive();
      for (int c = 0; c <= ar_wait; c++) begin
         arready = (c == ar_wait);
         @(negedge clock);
         chk("ar_arvalid", arvalid, 1);
         chk("ar_arid", arid, eid);
         chk("ar_araddr", araddr, la);
         chk("ar_arlen", arlen, ll);
         chk("ar_arsize", arsize, ls);
         chk("ar_arburst", arburst, 2'b01);
         chk("ar_lock_cache_prot", {arlock, arcache, arprot}, 0);
         chk("ar_rready", rready, 0);
         chk("ar_resp_valid", {inst_resp_valid, data_resp_valid}, 0);
         chk("ar_req_ready", {inst_req_ready, data_req_ready}, 0);
         @(posedge clock); #1;
      end
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      beat = 0; cyc = 0;
      while (beat <= int'(ll) && cyc < 300) begin
         if (abort_after >= 0 && beat == abort_after) return;
         go  = ($urandom_range(99) >= gap_pct);
         bad = (beat == bad_beat) || (bad_beat == -2 && $urandom_range(9) == 0);
         rvalid = go;
         if (!bad) rid = eid;
         else if (bad_beat == -2) rid = eid ^ 4'(1 + $urandom_range(14));
         else rid = eid ^ 4'd1;
         rdata = $urandom;
         rresp = rand_resp ? 2'($urandom_range(3)) : ((beat == err_beat) ? 2'b10 : 2'b00);
         rlast = (beat == int'(ll));
         fwd = go && !bad;
         @(negedge clock);
         chk("r_rready", rready, 1);
         chk("r_id_mismatch", id_mismatch, mism_exp);
         chk("r_req_ready", {inst_req_ready, data_req_ready}, 0);
         chk("r_own_valid", g ? data_resp_valid : inst_resp_valid, fwd);
         chk("r_other_valid", g ? inst_resp_valid : data_resp_valid, 0);
         if (fwd) begin
            chk("r_data", g ? data_resp_data : inst_resp_data, rdata);
            chk("r_last", g ? data_resp_last : inst_resp_last, rlast);
            chk("r_err", g ? data_resp_err : inst_resp_err, rresp != 2'b00);
         end
         @(posedge clock); #1;
         if (go && bad) mism_exp = 1'b1;
         if (go) beat++;
         cyc++;
      end
      if (cyc >= 300) begin
         n_chk++;
         $display("FAIL beat_budget: got %0d beats want %0d", beat, int'(ll) + 1);
      end
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1, 1, 0, 32'h1C00_0000, 32'h0, 8'd3, 3'd2, 0, -1, -1, 0};
      tbl[1] = '{1, 1, 1, 32'h1C00_0100, 32'h8000_0000, 8'd2, 3'd2, 0, -1, -1, 1};
      tbl[2] = '{0, 1, 1, 32'h1C00_0100, 32'h8000_0040, 8'd2, 3'd2, 1, -1, -1, 0};
      tbl[3] = '{0, 0, 1, 32'h0, 32'h8000_0040, 8'd2, 3'd2, 5, -1, -1, 1};
      tbl[4] = '{0, 0, 1, 32'h0, 32'h8000_0080, 8'd0, 3'd1, 0, 0, -1, 1};
      tbl[5] = '{0, 1, 0, 32'h1C00_0200, 32'h0, 8'd3, 3'd2, 2, 2, -1, 0};
      tbl[6] = '{0, 1, 0, 32'h1C00_0300, 32'h0, 8'd3, 3'd2, 0, -1, 1, 0};
      tbl[7] = '{1, 0, 1, 32'h0, 32'h8000_0100, 8'd1, 3'd2, 0, -1, -1, 1};

      rq[0] = '{0, 32'h0, 8'h0, 3'h0};
      rq[1] = '{0, 32'h0, 8'h0, 3'h0};
      last_g = 1'b0; mism_exp = 1'b0;
      rdata = '0; rresp = '0;
      do_reset(1'b0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset(1'b0);
         rq[0] = '{tbl[i].iv, tbl[i].ia, tbl[i].len, tbl[i].size};
         rq[1] = '{tbl[i].dv, tbl[i].da, tbl[i].len, tbl[i].size};
         run_burst(tbl[i].exp_g, tbl[i].ar_wait, tbl[i].err_beat, tbl[i].bad_beat, 0, -1, 0);
      end

      // Reset lands mid-burst with the slave still presenting beats.
      do_reset(1'b0);
      rq[0] = '{1, 32'h1C00_0400, 8'd7, 3'd2};
      run_burst(0, 0, -1, -1, 0, 2, 0);
      do_reset(1'b1);
      rq[1] = '{1, 32'h8000_0200, 8'd2, 3'd2};
      run_burst(1, 0, -1, -1, 0, -1, 0);

      do_reset(1'b0);
      for (int it = 0; it < 40; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!rq[r].v && $urandom_range(9) < 7)
               rq[r] = '{1, 32'($urandom), 8'($urandom_range(7)), 3'($urandom_range(2))};
         end
         if (!rq[0].v && !rq[1].v)
            rq[it % 2] = '{1, 32'($urandom), 8'($urandom_range(7)), 3'd2};
         run_burst(-1, $urandom_range(3), -1, -2, 30, -1, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have one clock, "clock", and one synchronous active-high reset, "reset"; polarity and synchronicity are fixed.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 {inst,data}_req_valid  in  1  requester has a read burst pending.
REQ-005 {inst,data}_req_ready  out  1  request accepted this cycle.
REQ-006 {inst,data}_req_addr  in  32  burst start address.
REQ-007 {inst,data}_req_len  in  8  AXI beats minus one.
REQ-008 {inst,data}_req_size  in  3  AXI beat size code.
REQ-009 {inst,data}_resp_valid  out  1  one returned beat for this requester.
REQ-010 {inst,data}_resp_data  out  32  beat data.
REQ-011 {inst,data}_resp_last  out  1  final beat of burst.
REQ-012 {inst,data}_resp_err  out  1  rresp of this beat is nonzero.
REQ-013 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR channel.
REQ-014 arready  in  1  AXI AR accept.
REQ-015 rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R channel.
REQ-016 rready  out  1  AXI R accept.

Function
REQ-017 The FSM SHALL have the states IDLE, AR and R, with one outstanding burst at most.
REQ-018 In IDLE with any req_valid, the block SHALL grant one requester, pulse its req_ready for one cycle, latch addr/len/size, and enter AR the next cycle.
REQ-019 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; the last_grant flop resets to inst, so data wins the first tie.
REQ-020 A single requester SHALL be granted immediately, independent of last_grant.
REQ-021 In AR, arvalid SHALL be 1 with the latched fields held stable; arid = 0 for inst and 1 for data; arburst = 2'b01; arlock, arcache and arprot = 0.
REQ-022 The AR handshake (arvalid && arready) SHALL move the FSM to R; arvalid SHALL stay high until then.
REQ-023 In R, rready SHALL be 1; each rvalid beat SHALL drive the granted requester's resp_valid in the same cycle (combinational), with resp_data = rdata, resp_last = rlast and resp_err = (rresp != 0).
REQ-024 A beat whose rid differs from the granted arid SHALL be accepted but not forwarded, and SHALL set sticky status bit id_mismatch.
REQ-025 rvalid && rlast SHALL return the FSM to IDLE; a new grant is possible on the following cycle, so there is at least one idle cycle between bursts.
REQ-026 The non-granted requester's resp_valid SHALL be 0 at all times; both resp_valid SHALL be 0 outside R.
REQ-027 req_ready SHALL be 0 in AR and R; requesters SHALL hold req_valid and fields until ready.
REQ-028 rvalid seen in IDLE or AR SHALL be ignored (rready = 0).
REQ-029 arlen SHALL pass through unmodified; the block SHALL NOT count beats and SHALL trust rlast.

Reset
REQ-030 On reset the block SHALL force state = IDLE, last_grant = inst and id_mismatch = 0; arvalid, rready, all req_ready and all resp_valid SHALL be 0 in the next cycle.
REQ-031 Reset asserted in AR or R SHALL abandon the burst without draining R.

Structure
REQ-032 The shared package SHALL hold the state enum, ID constants (INST_ID = 0, DATA_ID = 1), BURST_INCR = 2'b01 and the requester-index typedef.
REQ-033 The round-robin grant logic SHALL be a sub-module, rr_arbiter2 (2 requests, last_grant in, one-hot grant out).

Verification
REQ-034 Inst only, addr 0x1C000000, len 3, size 2 -> arid 0, arlen 3; 4 beats routed to inst; resp_last on beat 4; FSM returns to IDLE.
REQ-035 Inst and data valid in the same cycle after reset -> data granted first (arid 1); with both still valid, inst granted next.
REQ-036 arready held 0 for 5 cycles -> arvalid and araddr stable for all 5 cycles; handshake on cycle 6.
REQ-037 Beat with rresp = 2'b10 -> resp_err = 1 on that beat only; burst completes normally.
REQ-038 rid = 1 during an inst burst -> beat not forwarded and id_mismatch = 1; reset clears it.
REQ-039 Reset in R mid-burst -> next cycle IDLE, rready = 0, all outputs at reset values; a fresh request is served.
